// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready add/subtract unit whose carry chain is cut
// into STAGES equal chunks with a register between chunks. The final stage
// registers the full sum together with the carry, overflow, zero and
// negative flags.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned CW   = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   // per-stage registers: operands (upper chunks still pending), partial sum, carry, valid
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic              c_q [STAGES];
   logic [STAGES-1:0] v_q;
   logic              ovf_q;
   logic              zero_q;
   logic              neg_q;

   // next-state values produced by each stage's chunk adder
   logic [WIDTH-1:0]  nxt_a [STAGES];
   logic [WIDTH-1:0]  nxt_b [STAGES];
   logic [WIDTH-1:0]  nxt_s [STAGES];
   logic              nxt_c [STAGES];
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] ld;
   logic              nxt_ovf;

   // load enables, resolved from the output back toward the input
   always_comb begin
      logic drain;
      drain = out_ready;
      ld    = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         ld[LAST-i] = !v_q[LAST-i] || drain;
         drain      = ld[LAST-i];
      end
   end

   assign in_ready = rst_n && ld[0];

   // chunk adders: stage 0 conditions the raw operands, later stages consume the previous stage's registers
   always_comb begin
      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      logic [WIDTH-1:0] ss;
      logic             sc;
      logic [CW:0]      t;
      sa      = '0;
      sb      = '0;
      ss      = '0;
      sc      = 1'b0;
      t       = '0;
      src_v   = '0;
      nxt_ovf = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            src_v[k] = in_valid && in_ready;
            sa       = a;
            sb       = sub ? ~b : b;
            ss       = '0;
            sc       = cin ^ sub;
         end else begin
            src_v[k] = v_q[k-1];
            sa       = a_q[k-1];
            sb       = b_q[k-1];
            ss       = s_q[k-1];
            sc       = c_q[k-1];
         end
         t = {1'b0, sa[k*CW +: CW]} + {1'b0, sb[k*CW +: CW]} + {{CW{1'b0}}, sc};
         nxt_a[k]              = sa;
         nxt_b[k]              = sb;
         nxt_s[k]              = ss;
         nxt_s[k][k*CW +: CW]  = t[CW-1:0];
         nxt_c[k]              = t[CW];
      end
      // operands of equal sign producing a result of the other sign; equals carry-in(MSB) ^ carry-out(MSB)
      nxt_ovf = (sa[WIDTH-1] == sb[WIDTH-1]) && (nxt_s[LAST][WIDTH-1] != sa[WIDTH-1]);
   end

   // pipeline registers; a stage only captures data when a valid operation moves into it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         v_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b1;
         neg_q  <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               v_q[k] <= src_v[k];
               if (src_v[k]) begin
                  a_q[k] <= nxt_a[k];
                  b_q[k] <= nxt_b[k];
                  s_q[k] <= nxt_s[k];
                  c_q[k] <= nxt_c[k];
               end
            end
         end
         if (ld[LAST] && src_v[LAST]) begin
            ovf_q  <= nxt_ovf;
            zero_q <= (nxt_s[LAST] == '0);
            neg_q  <= nxt_s[LAST][WIDTH-1];
         end
      end
   end

   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and random checks of pipelined_addsub
// (WIDTH=32, STAGES=2) against an arithmetic reference model.
module tb_pipelined_addsub;

   localparam int W = 32;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;
   logic         neg;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        o;
      logic        z;
      logic        n;
   } res_t;

   res_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   npop = 0;
   logic acc = 1'b0;

   pipelined_addsub #(.WIDTH(W), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
      .zero(zero), .neg(neg)
   );

   always #5 clk = ~clk;

   // reference: plain integer arithmetic on 64-bit values
   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, input logic ci);
      longint ux, uy, sx, sy, ru, rs, cc;
      res_t   r;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      cc = ci ? 64'sd1 : 64'sd0;
      if (!s) begin
         ru  = ux + uy + cc;
         rs  = sx + sy + cc;
         r.c = (ru > 64'sd4294967295);
      end else begin
         ru  = ux - uy - cc;
         rs  = sx - sy - cc;
         r.c = (ux >= uy + cc);
      end
      r.s = ru[31:0];
      r.o = (rs > MAXS) || (rs < MINS);
      r.z = (r.s == 32'h0);
      r.n = r.s[31];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // one clock: sample transfers at the falling edge, then advance past the rising edge
   task automatic step();
      res_t e;
      @(negedge clk);
      acc = 1'b0;
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", {31'b0, out_valid}, 32'h0);
            end else begin
               e = q.pop_front();
               npop++;
               chk("sum", sum, e.s);
               chk("flags", {28'b0, cout, ovf, zero, neg}, {28'b0, e.c, e.o, e.z, e.n});
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, sub, cin));
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic ci);
      in_valid = v;
      a = x;
      b = y;
      sub = s;
      cin = ci;
   endtask

   // one isolated operation with out_ready high: latency and literal result checked
   task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input logic ci, input logic [31:0] exp_sum);
      int lat;
      drive(1'b1, x, y, s, ci);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, 2);
      chk({tag, "_sum_lit"}, sum, exp_sum);
      step();
   endtask

   initial begin
      int   n;
      int   p0;
      logic [31:0] held;
      logic [31:0] pick [5];

      // reset state
      rst_n = 1'b0;
      step();
      step();
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_flags", {28'b0, cout, ovf, zero, neg}, 32'h2);
      chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      // directed single operations
      single("add_carry", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE);
      single("chunk_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000);
      single("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000);
      single("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF);
      single("sub_zero", 32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000);
      single("sub_cin", 32'h00000005, 32'h00000002, 1'b1, 1'b1, 32'h00000002);
      single("add_cin", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000);

      // streaming: four back-to-back ops, out_valid from cycle 2
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i + 1), 32'(i + 1), 1'b0, 1'b0);
         chk("stream_in_ready", {31'b0, in_ready}, 32'h1);
         step();
         chk("stream_out_valid", {31'b0, out_valid}, (i + 1 >= 2) ? 32'h1 : 32'h0);
      end
      in_valid = 1'b0;
      step();
      chk("stream_out_valid_c5", {31'b0, out_valid}, 32'h1);
      step();
      chk("stream_out_valid_c6", {31'b0, out_valid}, 32'h0);
      chk("stream_drained", q.size(), 0);

      // backpressure: capacity two, output held stable
      out_ready = 1'b0;
      p0 = npop;
      drive(1'b1, 32'h00000010, 32'h00000001, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h00000020, 32'h00000002, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h00000030, 32'h00000003, 1'b0, 1'b0);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      held = sum;
      chk("bp_first_sum", held, 32'h00000011);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_sum", sum, held);
         chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
         chk("bp_hold_ready", {31'b0, in_ready}, 32'h0);
      end
      out_ready = 1'b1;
      n = 0;
      while ((q.size() > 0 || in_valid) && n < 20) begin
         step();
         if (acc) in_valid = 1'b0;
         n++;
      end
      chk("bp_drain_bound", {31'b0, (n < 20)}, 32'h1);
      chk("bp_pop_count", npop - p0, 3);
      for (int i = 0; i < 3; i++) step();

      // random traffic with random backpressure
      pick[0] = 32'h00000000;
      pick[1] = 32'hFFFFFFFF;
      pick[2] = 32'h7FFFFFFF;
      pick[3] = 32'h80000000;
      pick[4] = 32'h0000FFFF;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom,
               ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         step();
         n++;
      end
      chk("rand_drained", q.size(), 0);

      // reset with two operations in flight
      out_ready = 1'b0;
      drive(1'b1, 32'h00000100, 32'h00000001, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h00000200, 32'h00000002, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("mid_rst_sum", sum, 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_idle", {31'b0, out_valid}, 32'h0);
      end
      single("post_rst_op", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789);
      chk("final_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
